uart_receiver: RTL and testbench

UART_RECEIVER -- requirements
Module: uart_receiver

---
 rtl/uart_pkg.sv | 19 +
 rtl/uart_sync2.sv | 35 +++
 rtl/uart_receiver.sv | 151 +++++++++++++++
 tb/tb_uart_receiver.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART receive path: the receiver FSM state type
// and the default oversampling ratio (50 MHz clock, 115200 baud).
// -----------------------------------------------------------------------------
package uart_pkg;

  // Default clk cycles per serial bit: 50_000_000 / 115_200 ~= 434.
  localparam int unsigned UART_CLKS_PER_BIT_DEFAULT = 434;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3,
    ST_BREAK = 3'd4
  } uart_state_e;

endpackage : uart_pkg

// File: rtl/uart_sync2.sv
// -----------------------------------------------------------------------------
// uart_sync2
// Two-flop synchronizer for a single asynchronous input bit.
//   clk       : destination clock
//   reset     : asynchronous, active-high; both flops load RESET_VAL
//   async_in  : asynchronous input
//   sync_out  : input resynchronized to clk (two-cycle latency)
// -----------------------------------------------------------------------------
module uart_sync2 #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic async_in,
  output logic sync_out
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      // NOTE: non-blocking so the second flop captures the first flop's
      // pre-edge value; blocking here would collapse the chain to one flop.
      meta_q <= async_in;
      sync_q <= meta_q;
    end
  end

  assign sync_out = sync_q;

endmodule : uart_sync2

// File: rtl/uart_receiver.sv
// -----------------------------------------------------------------------------
// uart_receiver
// 8N1 UART receiver, LSB first. The start bit is re-checked at its middle,
// then each data bit and the stop bit are sampled one bit period apart.
//   clk             : sole clock, all state on rising edge
//   reset           : asynchronous, active-high
//   rx              : asynchronous serial line, idle high
//   dataWriteEnable : one-cycle pulse, dataWrite holds a new byte
//   dataWrite       : last correctly framed byte
//   framingError    : one-cycle pulse, stop bit was sampled low
//   busy            : high whenever the FSM is not idle
// There is no backpressure: every good frame produces a write pulse.
// -----------------------------------------------------------------------------
module uart_receiver
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = UART_CLKS_PER_BIT_DEFAULT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic       dataWriteEnable,
  output logic [7:0] dataWrite,
  output logic       framingError,
  output logic       busy
);

  // Counter only ever reaches CLKS_PER_BIT-1, so $clog2 bits never wrap.
  localparam int unsigned CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

  logic rxs;

  uart_sync2 #(
    .RESET_VAL (1'b1)
  ) u_sync (
    .clk      (clk),
    .reset    (reset),
    .async_in (rx),
    .sync_out (rxs)
  );

  uart_state_e   state_q,   state_d;
  logic [CW-1:0] cnt_q,     cnt_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [7:0]    shift_q,   shift_d;
  logic [7:0]    data_q,    data_d;
  logic          we_q,      we_d;
  logic          ferr_q,    ferr_d;

  always_comb begin
    // NOTE: every signal gets a default first so no branch can leave it
    // unassigned, which is what would otherwise infer a latch.
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    data_d    = data_q;
    we_d      = 1'b0;
    ferr_d    = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (!rxs) begin
          state_d = ST_START;
          cnt_d   = '0;
        end
      end

      // Wait half a bit so all later samples land mid-bit; a line that is
      // high again by then was only a glitch.
      ST_START: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d     = '0;
          bit_idx_d = '0;
          state_d   = rxs ? ST_IDLE : ST_DATA;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      ST_DATA: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d   = '0;
          shift_d = {rxs, shift_q[7:1]};
          if (bit_idx_q == 3'd7) begin
            state_d = ST_STOP;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      ST_STOP: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d = '0;
          if (rxs) begin
            data_d  = shift_q;
            we_d    = 1'b1;
            state_d = ST_IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = ST_BREAK;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      // Held-low line: one framing error already reported, wait for idle.
      ST_BREAK: begin
        if (rxs) begin
          state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      // NOTE: the shift register is eight plain flops, not a RAM, so it is
      // reset with the rest of the datapath to keep its contents defined.
      shift_q   <= '0;
      data_q    <= '0;
      we_q      <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      we_q      <= we_d;
      ferr_q    <= ferr_d;
    end
  end

  assign dataWriteEnable = we_q;
  assign dataWrite       = data_q;
  assign framingError    = ferr_q;
  assign busy            = (state_q != ST_IDLE);

endmodule : uart_receiver

// File: tb/tb_uart_receiver.sv
// -----------------------------------------------------------------------------
// tb_uart_receiver
// Self-checking bench for uart_receiver with CLKS_PER_BIT = 16. Stimulus is
// driven and outputs are sampled on the falling clock edge. A monitor
// collects write pulses, framing errors and feeds an optional 4-entry ring
// buffer model; each test task compares against values it predicts itself.
// -----------------------------------------------------------------------------
module tb_uart_receiver;

  localparam int CPB = 16;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       rx = 1'b1;
  logic       dataWriteEnable;
  logic [7:0] dataWrite;
  logic       framingError;
  logic       busy;

  int total = 0;
  int bad   = 0;

  // Bench-side reference: value dataWrite should currently hold.
  logic [7:0] last_good = 8'h00;

  // Monitor state (written only by the monitor process).
  logic [7:0] got_q[$];
  int wr_cnt   = 0;
  int fe_cnt   = 0;
  int both_cnt = 0;
  int long_cnt = 0;
  logic prev_we = 1'b0;
  logic prev_fe = 1'b0;

  // 4-entry ring buffer model downstream of the receiver.
  logic       rb_en = 1'b0;
  logic [7:0] rb_mem[4];
  int rb_wr   = 0;
  int rb_cnt  = 0;
  int rb_drop = 0;

  uart_receiver #(
    .CLKS_PER_BIT (CPB)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .rx              (rx),
    .dataWriteEnable (dataWriteEnable),
    .dataWrite       (dataWrite),
    .framingError    (framingError),
    .busy            (busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (dataWriteEnable) begin
      got_q.push_back(dataWrite);
      wr_cnt++;
      if (rb_en) begin
        if (rb_cnt < 4) begin
          rb_mem[rb_wr] = dataWrite;
          rb_wr = (rb_wr + 1) % 4;
          rb_cnt++;
        end else begin
          rb_drop++;
        end
      end
    end
    if (framingError) fe_cnt++;
    if (dataWriteEnable && framingError) both_cnt++;
    if ((dataWriteEnable && prev_we) || (framingError && prev_fe)) long_cnt++;
    prev_we = dataWriteEnable;
    prev_fe = framingError;
  end

  // Drives one 8N1 frame; rx is left at the stop-bit level afterwards.
  task automatic send_frame(input logic [7:0] b, input logic stop);
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    rx = stop;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    rx    = 1'b1;
    repeat (3) @(negedge clk);
    total++; if (dataWriteEnable !== 1'b0) begin bad++; $display("FAIL reset_we got=%b want=0", dataWriteEnable); end
    total++; if (dataWrite !== 8'h00) begin bad++; $display("FAIL reset_data got=%h want=00", dataWrite); end
    total++; if (framingError !== 1'b0) begin bad++; $display("FAIL reset_fe got=%b want=0", framingError); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    reset = 1'b0;
    idle(CPB);
    last_good = 8'h00;
  endtask

  task automatic test_single();
    int w0 = wr_cnt;
    int f0 = fe_cnt;
    int g0 = got_q.size();
    send_frame(8'h55, 1'b1);
    idle(2 * CPB);
    last_good = 8'h55;
    total++; if (wr_cnt - w0 !== 1) begin bad++; $display("FAIL single_wr_count got=%0d want=1", wr_cnt - w0); end
    total++; if (got_q.size() > g0 && got_q[g0] !== 8'h55) begin bad++; $display("FAIL single_byte got=%h want=55", got_q[g0]); end
    total++; if (fe_cnt - f0 !== 0) begin bad++; $display("FAIL single_fe got=%0d want=0", fe_cnt - f0); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL single_busy got=%b want=0", busy); end
    total++; if (dataWrite !== 8'h55) begin bad++; $display("FAIL single_hold got=%h want=55", dataWrite); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp[3];
    int w0 = wr_cnt;
    int g0 = got_q.size();
    exp[0] = 8'h00; exp[1] = 8'hFF; exp[2] = 8'hA3;
    for (int i = 0; i < 3; i++) send_frame(exp[i], 1'b1);
    idle(2 * CPB);
    last_good = 8'hA3;
    total++; if (wr_cnt - w0 !== 3) begin bad++; $display("FAIL b2b_count got=%0d want=3", wr_cnt - w0); end
    for (int i = 0; i < 3; i++) begin
      total++;
      if (got_q.size() <= g0 + i || got_q[g0 + i] !== exp[i]) begin
        bad++;
        $display("FAIL b2b_byte%0d got=%h want=%h", i, (got_q.size() > g0 + i) ? got_q[g0 + i] : 8'hxx, exp[i]);
      end
    end
  endtask

  task automatic test_glitch();
    int w0 = wr_cnt;
    int f0 = fe_cnt;
    rx = 1'b0;
    repeat (4) @(negedge clk);
    idle(3 * CPB);
    total++; if (wr_cnt - w0 !== 0) begin bad++; $display("FAIL glitch_wr got=%0d want=0", wr_cnt - w0); end
    total++; if (fe_cnt - f0 !== 0) begin bad++; $display("FAIL glitch_fe got=%0d want=0", fe_cnt - f0); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL glitch_busy got=%b want=0", busy); end
  endtask

  task automatic test_break();
    int w0 = wr_cnt;
    int f0 = fe_cnt;
    send_frame(8'h3C, 1'b0);
    repeat (40) @(negedge clk);
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL break_busy_low got=%b want=1", busy); end
    total++; if (fe_cnt - f0 !== 1) begin bad++; $display("FAIL break_fe got=%0d want=1", fe_cnt - f0); end
    total++; if (wr_cnt - w0 !== 0) begin bad++; $display("FAIL break_wr got=%0d want=0", wr_cnt - w0); end
    total++; if (dataWrite !== last_good) begin bad++; $display("FAIL break_hold got=%h want=%h", dataWrite, last_good); end
    idle(2 * CPB);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL break_busy_idle got=%b want=0", busy); end
    total++; if (fe_cnt - f0 !== 1) begin bad++; $display("FAIL break_fe_final got=%0d want=1", fe_cnt - f0); end
  endtask

  task automatic test_reset_midframe();
    logic [7:0] b = 8'h81;
    int w0 = wr_cnt;
    int f0 = fe_cnt;
    int g0;
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    rx = b[3];
    repeat (CPB / 2) @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    last_good = 8'h00;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_mid_busy got=%b want=0", busy); end
    total++; if (dataWrite !== 8'h00) begin bad++; $display("FAIL rst_mid_data got=%h want=00", dataWrite); end
    total++; if (dataWriteEnable !== 1'b0 || framingError !== 1'b0) begin bad++; $display("FAIL rst_mid_pulse got=%b%b want=00", dataWriteEnable, framingError); end
    rx = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    idle(2 * CPB);
    total++; if (wr_cnt - w0 !== 0 || fe_cnt - f0 !== 0) begin bad++; $display("FAIL rst_mid_no_pulse got=wr%0d/fe%0d want=0/0", wr_cnt - w0, fe_cnt - f0); end
    g0 = got_q.size();
    send_frame(8'h7E, 1'b1);
    idle(2 * CPB);
    last_good = 8'h7E;
    total++; if (got_q.size() != g0 + 1 || got_q[g0] !== 8'h7E) begin bad++; $display("FAIL rst_mid_next got=%0d bytes want=1 byte 7e", got_q.size() - g0); end
  endtask

  task automatic test_ring_buffer();
    logic [7:0] sent[5];
    int w0 = wr_cnt;
    for (int i = 0; i < 5; i++) sent[i] = 8'($urandom);
    rb_en = 1'b1;
    for (int i = 0; i < 5; i++) send_frame(sent[i], 1'b1);
    idle(2 * CPB);
    rb_en = 1'b0;
    last_good = sent[4];
    total++; if (wr_cnt - w0 !== 5) begin bad++; $display("FAIL rb_rx_writes got=%0d want=5", wr_cnt - w0); end
    total++; if (rb_cnt !== 4) begin bad++; $display("FAIL rb_fill got=%0d want=4", rb_cnt); end
    total++; if (rb_drop !== 1) begin bad++; $display("FAIL rb_drop got=%0d want=1", rb_drop); end
    for (int i = 0; i < 4; i++) begin
      total++;
      if (rb_mem[i] !== sent[i]) begin bad++; $display("FAIL rb_read%0d got=%h want=%h", i, rb_mem[i], sent[i]); end
    end
  endtask

  task automatic test_random();
    logic [7:0] exp_q[$];
    int exp_fe = 0;
    int w0 = wr_cnt;
    int f0 = fe_cnt;
    int g0 = got_q.size();
    for (int n = 0; n < 24; n++) begin
      logic [7:0] b = 8'($urandom);
      logic stop = ($urandom_range(4) != 0);
      int gap;
      send_frame(b, stop);
      if (stop) begin
        exp_q.push_back(b);
        last_good = b;
        gap = $urandom_range(2 * CPB);
      end else begin
        exp_fe++;
        gap = $urandom_range(2 * CPB, 4);
      end
      idle(gap);
    end
    idle(2 * CPB);
    total++; if (wr_cnt - w0 !== exp_q.size()) begin bad++; $display("FAIL rand_wr_count got=%0d want=%0d", wr_cnt - w0, exp_q.size()); end
    total++; if (fe_cnt - f0 !== exp_fe) begin bad++; $display("FAIL rand_fe_count got=%0d want=%0d", fe_cnt - f0, exp_fe); end
    for (int i = 0; i < exp_q.size(); i++) begin
      total++;
      if (got_q.size() <= g0 + i || got_q[g0 + i] !== exp_q[i]) begin
        bad++;
        $display("FAIL rand_byte%0d got=%h want=%h", i, (got_q.size() > g0 + i) ? got_q[g0 + i] : 8'hxx, exp_q[i]);
      end
    end
    total++; if (dataWrite !== last_good) begin bad++; $display("FAIL rand_hold got=%h want=%h", dataWrite, last_good); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rand_busy got=%b want=0", busy); end
  endtask

  task automatic test_pulse_shape();
    total++; if (both_cnt !== 0) begin bad++; $display("FAIL pulse_overlap got=%0d want=0", both_cnt); end
    total++; if (long_cnt !== 0) begin bad++; $display("FAIL pulse_width got=%0d want=0", long_cnt); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_glitch();
    test_break();
    test_reset_midframe();
    test_ring_buffer();
    test_random();
    test_pulse_shape();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_uart_receiver
